// File: rtl/encrypt_stream.sv
// Streaming LWE-style encryptor: sums mask-selected public-key entries per row (mod q),
// then adds the scaled plaintext on the final b-row.
module encrypt_stream #(
  parameter int unsigned PLAINTEXT_MODULUS  = 64,
  parameter int unsigned PLAINTEXT_WIDTH    = 6,
  parameter int unsigned DIMENSION          = 1,
  parameter int unsigned CIPHERTEXT_MODULUS = 1024,
  parameter int unsigned CIPHERTEXT_WIDTH   = 21,
  parameter int unsigned BIG_N              = 30,
  parameter int unsigned LANES              = 1,
  localparam int unsigned ROW_W = (DIMENSION + 1 > 1) ? $clog2(DIMENSION + 1) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                go,
  input  logic [PLAINTEXT_WIDTH-1:0]          plaintext,
  input  logic [BIG_N-1:0]                    noise_select,
  input  logic                                key_valid,
  output logic                                key_ready,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   key_data,
  output logic                                ct_valid,
  input  logic                                ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]         ct_data,
  output logic [ROW_W-1:0]                    ct_row,
  output logic                                ct_last,
  output logic                                busy
);

  localparam int unsigned Q_W    = $clog2(CIPHERTEXT_MODULUS);
  localparam int unsigned BEATS  = BIG_N / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SCALE  = CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS;

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  state_e                     r_state;
  state_e                     w_state_next;
  logic [PLAINTEXT_WIDTH-1:0] r_plaintext;
  logic [BIG_N-1:0]           r_mask;
  logic [Q_W-1:0]             r_acc;
  logic [ROW_W-1:0]           r_row;
  logic [BEAT_W-1:0]          r_beat;

  logic [LANES-1:0]           w_lane_sel;
  logic [Q_W-1:0]             w_beat_sum;
  logic [Q_W-1:0]             w_pt_scaled;
  logic [Q_W-1:0]             w_row_value;
  logic                       w_go_accept;
  logic                       w_beat_accept;
  logic                       w_last_beat;
  logic                       w_ct_accept;
  logic                       w_is_b_row;
  logic                       w_unused_key;

  // Only the low log2(q) bits of each key word matter since q is a power of two.
  assign w_unused_key = ^key_data;

  assign w_go_accept   = (r_state == StIdle) && go;
  assign w_beat_accept = (r_state == StAccum) && key_valid;
  assign w_last_beat   = (r_beat == BEAT_W'(BEATS - 1));
  assign w_ct_accept   = (r_state == StEmit) && ct_ready;
  assign w_is_b_row    = (r_row == ROW_W'(DIMENSION));
  assign w_lane_sel    = r_mask[r_beat * LANES +: LANES];
  assign w_pt_scaled   = Q_W'(r_plaintext) * Q_W'(SCALE);
  assign w_row_value   = w_is_b_row ? (r_acc + w_pt_scaled) : r_acc;

  always_comb begin
    w_beat_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      if (w_lane_sel[j]) begin
        w_beat_sum = w_beat_sum + key_data[j * CIPHERTEXT_WIDTH +: Q_W];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (go) w_state_next = StAccum;
      StAccum: if (key_valid && w_last_beat) w_state_next = StEmit;
      StEmit:  if (ct_ready) w_state_next = w_is_b_row ? StIdle : StAccum;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    key_ready = (r_state == StAccum);
    busy      = (r_state != StIdle);
    ct_valid  = (r_state == StEmit);
    ct_last   = 1'b0;
    ct_row    = '0;
    ct_data   = '0;
    if (r_state == StEmit) begin
      ct_last            = w_is_b_row;
      ct_row             = r_row;
      ct_data[Q_W-1:0]   = w_row_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_plaintext <= '0;
      r_mask      <= '0;
      r_acc       <= '0;
      r_row       <= '0;
      r_beat      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_go_accept) begin
        r_plaintext <= plaintext;
        r_mask      <= noise_select;
        r_acc       <= '0;
        r_row       <= '0;
        r_beat      <= '0;
      end
      if (w_beat_accept) begin
        r_acc  <= r_acc + w_beat_sum;
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
      // After a non-final row, restart accumulation for the next row immediately.
      if (w_ct_accept && !w_is_b_row) begin
        r_acc  <= '0;
        r_row  <= r_row + 1'b1;
        r_beat <= '0;
      end
    end
  end

endmodule

// File: tb/tb_encrypt_stream.sv
// Scoreboard bench for encrypt_stream: directed cases with fixed expected ciphertexts plus
// randomized encryptions checked against an arithmetic reference model.
module tb_encrypt_stream;

  localparam int unsigned BIG_N = 4;
  localparam int unsigned LANES = 2;
  localparam int unsigned DIM   = 1;
  localparam int unsigned P     = 64;
  localparam int unsigned PW    = 6;
  localparam int unsigned Q     = 1024;
  localparam int unsigned CW    = 21;
  localparam int unsigned ROWS  = DIM + 1;
  localparam int unsigned BEATS = BIG_N / LANES;

  logic                  clk;
  logic                  rst_n;
  logic                  go;
  logic [PW-1:0]         plaintext;
  logic [BIG_N-1:0]      noise_select;
  logic                  key_valid;
  logic                  key_ready;
  logic [LANES*CW-1:0]   key_data;
  logic                  ct_valid;
  logic                  ct_ready;
  logic [CW-1:0]         ct_data;
  logic [0:0]            ct_row;
  logic                  ct_last;
  logic                  busy;

  typedef struct {
    int data;
    int row;
    int last;
  } exp_t;

  exp_t        sb[$];
  int unsigned keys[ROWS*BIG_N];
  int          n_checks = 0;
  int          n_err = 0;
  int          rdy_mode = 0;
  bit          bp_done = 0;
  int          bp_expect = 0;

  encrypt_stream #(
    .PLAINTEXT_MODULUS (P),
    .PLAINTEXT_WIDTH   (PW),
    .DIMENSION         (DIM),
    .CIPHERTEXT_MODULUS(Q),
    .CIPHERTEXT_WIDTH  (CW),
    .BIG_N             (BIG_N),
    .LANES             (LANES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .plaintext   (plaintext),
    .noise_select(noise_select),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_data    (key_data),
    .ct_valid    (ct_valid),
    .ct_ready    (ct_ready),
    .ct_data     (ct_data),
    .ct_row      (ct_row),
    .ct_last     (ct_last),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key_ready"}, 32'(key_ready), 0);
    check({tag, "_ct_valid"}, 32'(ct_valid), 0);
    check({tag, "_ct_data"}, 32'(ct_data), 0);
    check({tag, "_ct_row"}, 32'(ct_row), 0);
    check({tag, "_ct_last"}, 32'(ct_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic push_exp(input int data, input int row, input int last);
    exp_t e;
    e.data = data;
    e.row  = row;
    e.last = last;
    sb.push_back(e);
  endtask

  // Reference: per row, sum of selected keys reduced mod q; b-row adds plaintext*(q/p).
  task automatic push_model(input int pt, input int mask);
    for (int r = 0; r < int'(ROWS); r++) begin
      int sum = 0;
      for (int i = 0; i < int'(BIG_N); i++) begin
        if (((mask >> i) & 1) == 1) sum += int'(keys[r*BIG_N+i] % Q);
      end
      sum = sum % int'(Q);
      if (r == int'(DIM)) sum = (sum + pt * int'(Q / P)) % int'(Q);
      push_exp(sum, r, (r == int'(DIM)) ? 1 : 0);
    end
  endtask

  task automatic set_basic_keys();
    int unsigned k[ROWS*BIG_N] = '{100, 200, 300, 400, 1000, 20, 30, 40};
    keys = k;
  endtask

  task automatic run_enc(input int pt, input int mask, input bit glitch);
    int  b;
    int  guard;
    bit  acc;
    guard = 0;
    while (busy && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    plaintext    = PW'(pt);
    noise_select = BIG_N'(mask);
    go           = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check("busy_after_go", 32'(busy), 1);
    b     = 0;
    guard = 0;
    while (b < int'(ROWS*BEATS) && guard < 1000) begin
      key_data = '0;
      for (int j = 0; j < int'(LANES); j++) key_data[j*CW +: CW] = CW'(keys[b*LANES+j]);
      key_valid = ($urandom_range(0, 3) != 0);
      if (glitch && b == 1) begin
        go           = 1'b1;
        plaintext    = ~PW'(pt);
        noise_select = ~BIG_N'(mask);
      end
      acc = key_valid && key_ready;
      @(posedge clk); #1;
      go = 1'b0;
      if (acc) begin
        b++;
        if (b % int'(BEATS) == 0) check("ct_valid_after_last_beat", 32'(ct_valid), 1);
      end
      guard++;
    end
    key_valid = 1'b0;
    check("all_beats_consumed", 32'(b), ROWS * BEATS);
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("scoreboard_drained", 32'(sb.size()), 0);
    check("idle_after_run", 32'(busy), 0);
  endtask

  // Monitor: compare every accepted ciphertext word against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ct_valid && ct_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ct_row", 32'(ct_row), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ct_data", 32'(ct_data), 32'(e.data));
        check("ct_row", 32'(ct_row), 32'(e.row));
        check("ct_last", 32'(ct_last), 32'(e.last));
      end
    end
  end

  // ct_ready driver: always-ready, random, or a 5-cycle stall on the first ciphertext word.
  initial begin
    ct_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: ct_ready = 1'b1;
        1: ct_ready = 1'($urandom_range(0, 1));
        default: begin
          if (ct_valid && !bp_done) begin
            ct_ready = 1'b0;
            for (int c = 0; c < 5; c++) begin
              @(negedge clk);
              check("bp_ct_valid", 32'(ct_valid), 1);
              check("bp_ct_data", 32'(ct_data), 32'(bp_expect));
              check("bp_key_ready", 32'(key_ready), 0);
              @(posedge clk); #1;
            end
            ct_ready = 1'b1;
            bp_done  = 1'b1;
          end else begin
            ct_ready = bp_done;
          end
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    go           = 1'b0;
    plaintext    = '0;
    noise_select = '0;
    key_valid    = 1'b0;
    key_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic case, two lanes per beat.
    set_basic_keys();
    push_exp(400, 0, 0);
    push_exp(86, 1, 1);
    run_enc(5, 4'b0101, 1'b0);

    // Wrap-around of the accumulator.
    for (int i = 0; i < int'(ROWS*BIG_N); i++) keys[i] = 1023;
    push_exp(1020, 0, 0);
    push_exp(1020, 1, 1);
    run_enc(0, 4'b1111, 1'b0);

    // Oversized key reduces mod q.
    begin
      int unsigned k[ROWS*BIG_N] = '{124312, 5, 6, 7, 124312, 0, 0, 0};
      keys = k;
    end
    push_exp(408, 0, 0);
    push_exp(408, 1, 1);
    run_enc(0, 4'b0001, 1'b0);

    // Zero mask leaves only the scaled plaintext.
    for (int i = 0; i < int'(ROWS*BIG_N); i++) keys[i] = $urandom_range(0, (1 << CW) - 1);
    push_exp(0, 0, 0);
    push_exp(1008, 1, 1);
    run_enc(63, 0, 1'b0);

    // Backpressure on the first ciphertext word.
    set_basic_keys();
    rdy_mode  = 2;
    bp_done   = 1'b0;
    bp_expect = 400;
    push_exp(400, 0, 0);
    push_exp(86, 1, 1);
    run_enc(5, 4'b0101, 1'b0);
    check("bp_stall_seen", 32'(bp_done), 1);
    rdy_mode = 0;

    // Asynchronous reset mid-ACCUM, then a fresh encryption.
    plaintext    = 6'd5;
    noise_select = 4'b0101;
    go           = 1'b1;
    @(posedge clk); #1;
    go        = 1'b0;
    key_valid = 1'b1;
    key_data  = {CW'(200), CW'(100)};
    @(posedge clk); #1;
    key_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_resume_busy", 32'(busy), 0);
    check("no_resume_key_ready", 32'(key_ready), 0);
    set_basic_keys();
    push_exp(400, 0, 0);
    push_exp(86, 1, 1);
    run_enc(5, 4'b0101, 1'b0);

    // go while busy must not disturb the latched operands.
    push_exp(400, 0, 0);
    push_exp(86, 1, 1);
    run_enc(5, 4'b0101, 1'b1);

    // Randomized encryptions with random ct_ready.
    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int pt;
      int mask;
      pt   = int'($urandom_range(0, P - 1));
      mask = int'($urandom_range(0, (1 << BIG_N) - 1));
      for (int i = 0; i < int'(ROWS*BIG_N); i++) keys[i] = $urandom_range(0, (1 << CW) - 1);
      push_model(pt, mask);
      run_enc(pt, mask, (t % 4) == 3);
    end
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
